// File: rtl/aes_sbox.sv
// AES forward S-box: GF(2^8) multiplicative inverse (x^254) followed by the FIPS-197 affine map.
// Purely combinational; zero maps to 0x63 because 0^254 = 0.
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    logic [7:0] inv;

    always_comb begin
        logic [7:0] pow;
        pow = data_i;
        inv = 8'h01;
        // Accumulates x^2 * x^4 * ... * x^128 = x^254.
        for (int i = 1; i < 8; i++) begin
            pow = gf_mul(pow, pow);
            inv = gf_mul(inv, pow);
        end
    end

    assign data_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: one round key per cycle into an 11-entry register file,
// with a registered 1-cycle-latency read port indexed by round_in.
module aes_key_schedule #(
    parameter int unsigned NR = 10
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         init_in,
    input  logic [127:0] key_in,
    input  logic [3:0]   round_in,
    output logic [127:0] round_key_out,
    output logic         ready_out
);

    typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

    state_e       state_q, state_d;
    logic [3:0]   ctr_q, ctr_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         ready_q, ready_d;
    logic [127:0] slots_q [0:NR];
    logic [127:0] rkey_q;

    logic         slot_we;
    logic [3:0]   slot_idx;
    logic [127:0] slot_wdata;
    logic [127:0] prev_key;
    logic [127:0] next_key;
    logic [127:0] rd_key;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;

    always_comb begin
        prev_key = '0;
        for (int i = 0; i < int'(NR); i++) begin
            if (ctr_q == 4'(i + 1)) prev_key = slots_q[i];
        end
    end

    assign rot_word = {prev_key[23:0], prev_key[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .data_i(rot_word[8*b +: 8]),
            .data_o(sub_word[8*b +: 8])
        );
    end

    always_comb begin
        logic [31:0] w0, w1, w2, w3;
        w0 = prev_key[127:96] ^ sub_word ^ {rcon_q, 24'h000000};
        w1 = prev_key[95:64] ^ w0;
        w2 = prev_key[63:32] ^ w1;
        w3 = prev_key[31:0] ^ w2;
        next_key = {w0, w1, w2, w3};
    end

    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        rcon_d     = rcon_q;
        ready_d    = ready_q;
        slot_we    = 1'b0;
        slot_idx   = ctr_q;
        slot_wdata = next_key;
        if (init_in) begin
            // A new key always wins, even mid-expansion.
            state_d    = StExpand;
            ctr_d      = 4'd1;
            rcon_d     = 8'h01;
            ready_d    = 1'b0;
            slot_we    = 1'b1;
            slot_idx   = 4'd0;
            slot_wdata = key_in;
        end else begin
            unique case (state_q)
                StExpand: begin
                    slot_we = 1'b1;
                    ctr_d   = ctr_q + 4'd1;
                    rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    if (ctr_q == 4'(NR)) begin
                        state_d = StReady;
                        ready_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_key = '0;
        for (int i = 0; i <= int'(NR); i++) begin
            if (round_in == 4'(i)) rd_key = slots_q[i];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            ctr_q   <= 4'd0;
            rcon_q  <= 8'h01;
            ready_q <= 1'b0;
            rkey_q  <= '0;
            for (int i = 0; i <= int'(NR); i++) slots_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            rcon_q  <= rcon_d;
            ready_q <= ready_d;
            rkey_q  <= rd_key;
            for (int i = 0; i <= int'(NR); i++) begin
                if (slot_we && slot_idx == 4'(i)) slots_q[i] <= slot_wdata;
            end
        end
    end

    assign round_key_out = rkey_q;
    assign ready_out     = ready_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench: driver pushes expected round keys, a monitor pops and compares one cycle later.
// Reference expansion is a word-array model with its own brute-force S-box table.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst_in;
    logic         init_in;
    logic [127:0] key_in;
    logic [3:0]   round_in;
    logic [127:0] round_key_out;
    logic         ready_out;

    aes_key_schedule #(.NR(10)) dut (
        .clk_in(clk),
        .rst_in(rst_in),
        .init_in(init_in),
        .key_in(key_in),
        .round_in(round_in),
        .round_key_out(round_key_out),
        .ready_out(ready_out)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int           due;
        logic [127:0] exp;
        string        name;
    } exp_t;
    exp_t sb[$];

    logic [7:0] sbox_tab [0:255];
    logic [7:0] rcon_tab [0:9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Carry-less product then reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] ref_gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                       ^ inv[(i + 7) % 8];
            sbox_tab[x] = s ^ 8'h63;
        end
        rcon_tab[0] = 8'h01; rcon_tab[1] = 8'h02; rcon_tab[2] = 8'h04; rcon_tab[3] = 8'h08;
        rcon_tab[4] = 8'h10; rcon_tab[5] = 8'h20; rcon_tab[6] = 8'h40; rcon_tab[7] = 8'h80;
        rcon_tab[8] = 8'h1b; rcon_tab[9] = 8'h36;
    endtask

    function automatic logic [127:0] ref_round_key(input logic [127:0] key, input int r);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rcon_tab[i/4 - 1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].due <= cycle) begin
                e = sb.pop_front();
                check(e.name, round_key_out, e.exp);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic read(input int r, input logic [127:0] exp, input string name);
        exp_t e;
        round_in = 4'(r);
        key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        e.due = cycle + 1;
        e.exp = exp;
        e.name = name;
        sb.push_back(e);
        step();
    endtask

    task automatic pulse_init(input logic [127:0] k);
        init_in = 1'b1;
        key_in = k;
        step();
        init_in = 1'b0;
        key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Called one negedge after the accepting edge; ready must rise on the 10th edge after it.
    task automatic wait_ready(input string name);
        for (int k = 1; k <= 10; k++) begin
            check({name, "_low"}, 128'(ready_out), 128'(0));
            key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
        end
        check({name, "_high"}, 128'(ready_out), 128'(1));
    endtask

    logic [127:0] fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] key_b    = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] k;
    int           r;

    initial begin
        build_tables();
        rst_in = 1'b1;
        init_in = 1'b0;
        key_in = '0;
        round_in = '0;
        step();
        step();
        check("reset_ready", 128'(ready_out), 128'(0));
        check("reset_rkey", round_key_out, 128'(0));
        rst_in = 1'b0;
        read(0, 128'(0), "reset_slot0");

        pulse_init(fips_key);
        wait_ready("fips_ready");
        read(1, 128'ha0fafe1788542cb123a339392a6c7605, "fips_r1");
        read(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_r10");
        read(0, fips_key, "fips_r0");
        for (int i = 10; i >= 0; i--) read(i, ref_round_key(fips_key, i), "sweep_down");
        for (int i = 11; i <= 15; i++) read(i, 128'(0), "out_of_range");

        pulse_init({$urandom(), $urandom(), $urandom(), $urandom()});
        for (int i = 0; i < 3; i++) begin
            check("restart_pre_low", 128'(ready_out), 128'(0));
            step();
        end
        pulse_init(key_b);
        wait_ready("restart_ready");
        read(10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "restart_r10");
        read(0, key_b, "restart_r0");

        repeat (6) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            pulse_init(k);
            wait_ready("rand_ready");
            repeat (20) begin
                r = $urandom_range(0, 15);
                read(r, (r <= 10) ? ref_round_key(k, r) : 128'(0), "rand_read");
            end
        end

        pulse_init({$urandom(), $urandom(), $urandom(), $urandom()});
        step();
        step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        check("rst_mid_ready", 128'(ready_out), 128'(0));
        check("rst_mid_rkey", round_key_out, 128'(0));
        read(0, 128'(0), "rst_mid_slot0");
        for (int i = 0; i < 12; i++) begin
            check("rst_mid_stays_low", 128'(ready_out), 128'(0));
            step();
        end

        pulse_init(fips_key);
        wait_ready("pre_rst_init_ready");
        rst_in = 1'b1;
        init_in = 1'b1;
        key_in = key_b;
        step();
        rst_in = 1'b0;
        init_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("rst_init_low", 128'(ready_out), 128'(0));
            step();
        end
        read(0, 128'(0), "rst_init_slot0");
        read(10, 128'(0), "rst_init_slot10");

        repeat (3) step();
        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
